mux_4to1: RTL and testbench

- Registered 4-to-1 bit selector.
- Each clock it samples a 5-bit input bus and a 2-bit select, and registers the selected bit onto a single-bit output.
- Used as a leaf datapath element wherever one of four status/data bits must be steered to a single line with a clean, glitch-free registered output.

---
 rtl/mux_4to1_if.sv | 29 ++
 rtl/mux_4to1.sv | 51 +++++
 tb/tb_mux_4to1.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mux_4to1_if.sv
// mux_4to1_if: bundles the data/select bus and the registered output of mux_4to1.
//   In  - data bus, In[3:0] selectable, In[IN_W-1:4] reserved
//   sel - channel select
//   Out - registered selected bit
// Modports:
//   master - drives In/sel, observes Out (the block's user)
//   slave  - consumes In/sel, drives Out (the selector itself)
interface mux_4to1_if #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned SEL_W = 2
) ();

    logic [IN_W-1:0]  In;
    logic [SEL_W-1:0] sel;
    logic             Out;

    modport master (
        output In,
        output sel,
        input  Out
    );

    modport slave (
        input  In,
        input  sel,
        output Out
    );

endinterface

// File: rtl/mux_4to1.sv
// mux_4to1: registered 4-to-1 bit selector.
// Every rising clk edge the bit In[sel] (sel = 0..3) is captured into a single flop that
// drives Out, giving one cycle of latency and a glitch-free output with no combinational
// path from In/sel to Out. In bits above 3 are reserved and never reach Out.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset; forces Out to RST_VAL while high
//   bus - mux_4to1_if slave modport carrying In, sel and Out
module mux_4to1 #(
    parameter int unsigned IN_W    = 5,
    parameter int unsigned SEL_W   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mux_4to1_if.slave  bus
);

    logic sel_bit;
    logic out_q;

    // Plain 4:1 mux. An unknown select falls to the default so X reaches Out in
    // simulation; synthesis treats it as a don't-care.
    always_comb begin
        sel_bit = 1'b0;
        unique case (bus.sel)
            2'd0:    sel_bit = bus.In[0];
            2'd1:    sel_bit = bus.In[1];
            2'd2:    sel_bit = bus.In[2];
            2'd3:    sel_bit = bus.In[3];
            default: sel_bit = 1'bx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RST_VAL;
        end else begin
            out_q <= sel_bit;
        end
    end

    assign bus.Out = out_q;

    // Reserved upper bits are deliberately left unconnected to the datapath.
    if (IN_W > 4) begin : gen_reserved
        logic unused_reserved;
        assign unused_reserved = ^bus.In[IN_W-1:4];
    end

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: directed self-checking bench for mux_4to1.
// Inputs change 1 ns after a rising edge; Out is sampled 1 ns after the following edge.
module tb_mux_4to1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mux_4to1_if #(.IN_W(5), .SEL_W(2)) bus_if ();

    mux_4to1 #(
        .IN_W    (5),
        .SEL_W   (2),
        .RST_VAL (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] cnt;
        logic [3:0] lo;
        logic [3:0] sweep_exp;

        // Reset holds Out low regardless of inputs and clock.
        rst = 1'b1;
        bus_if.In  = 5'b01111;
        bus_if.sel = 2'd3;
        #1;
        check_bit("rst_initial", bus_if.Out, 1'b0);
        step();
        check_bit("rst_hold_1", bus_if.Out, 1'b0);
        step();
        check_bit("rst_hold_2", bus_if.Out, 1'b0);

        // Release, then assert reset between edges while Out is 1.
        rst = 1'b0;
        step();
        check_bit("release_load", bus_if.Out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_async_drop", bus_if.Out, 1'b0);
        step();
        rst = 1'b0;

        // Static sweep over every select value; also confirm no combinational path.
        bus_if.In = 5'b00101;
        sweep_exp = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            bus_if.sel = 2'(s);
            if (s > 0) begin
                #2;
                check_bit("no_comb_path", bus_if.Out, sweep_exp[s-1]);
            end
            step();
            check_bit($sformatf("sweep_sel%0d", s), bus_if.Out, sweep_exp[s]);
        end

        // Counting stimulus: In increments every clock, 100 clocks per select value.
        cnt = 5'd0;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 100; k++) begin
                bus_if.In  = cnt;
                bus_if.sel = 2'(s);
                step();
                check_bit($sformatf("count_sel%0d_in%0d", s, cnt), bus_if.Out, cnt[s]);
                cnt = cnt + 5'd1;
            end
        end

        // Reserved bit In[4] must never matter.
        lo = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 2; b++) begin
                bus_if.In  = {1'(b), lo};
                bus_if.sel = 2'(s);
                step();
                check_bit($sformatf("reserved_sel%0d_b%0d", s, b), bus_if.Out, lo[s]);
            end
        end

        // Simultaneous change of In and sel before one edge.
        bus_if.In  = 5'b00010;
        bus_if.sel = 2'd0;
        step();
        check_bit("simul_pre", bus_if.Out, 1'b0);
        bus_if.In  = 5'b01000;
        bus_if.sel = 2'd3;
        step();
        check_bit("simul_new", bus_if.Out, 1'b1);

        // Reset release with sel=2, In[2]=1.
        rst = 1'b1;
        #1;
        check_bit("rst2_async", bus_if.Out, 1'b0);
        bus_if.In  = 5'b00100;
        bus_if.sel = 2'd2;
        step();
        check_bit("rst2_hold", bus_if.Out, 1'b0);
        rst = 1'b0;
        step();
        check_bit("rst2_release", bus_if.Out, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
